// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART types (rx state encoding, parity mode constants)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous input bit
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm : oversampling UART receiver with optional parity, frame/parity
//               error pulses and break handling
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fsm #(
  parameter int clks_per_bit = 16,
  parameter int rx_num_bits  = 8,
  parameter int parity       = 0
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int              CW         = $clog2(clks_per_bit);
  localparam logic [CW-1:0]   c_half     = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0]   c_full     = CW'(clks_per_bit - 1);
  localparam logic [2:0]      c_last_bit = 3'(rx_num_bits - 1);
  localparam bit              c_has_par  = (parity != PAR_NONE);

  logic          w_rx_s;
  rx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift;
  logic          r_mismatch;
  logic [7:0]    r_data_out;
  logic          r_data_valid, r_parity_err, r_frame_err;
  logic          w_frame_start, w_sample_data, w_sample_par;
  logic          w_stop_good, w_stop_bad, w_par_mis;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (RST),
    .i_d (RX),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= RX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CW'(1);
    w_bit_nxt     = r_bit;
    w_frame_start = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_stop_good   = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt   = RX_START;
          w_frame_start = 1'b1;
        end
      end
      RX_START: begin
        if (r_cnt == c_half) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_full) begin
          w_cnt_nxt     = '0;
          w_sample_data = 1'b1;
          w_bit_nxt     = r_bit + 3'd1;
          if (r_bit == c_last_bit) w_state_nxt = c_has_par ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (r_cnt == c_full) begin
          w_cnt_nxt    = '0;
          w_sample_par = 1'b1;
          w_state_nxt  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_full) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_stop_good = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // The shift register is cleared per frame so bits above rx_num_bits read zero.
  assign w_par_mis = (parity == PAR_ODD) ? ~(^r_shift ^ w_rx_s) : (^r_shift ^ w_rx_s);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_mismatch   <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_data_valid <= w_stop_good;
      r_parity_err <= w_stop_good & r_mismatch;
      r_frame_err  <= w_stop_bad;
      if (w_frame_start) begin
        r_shift    <= '0;
        r_mismatch <= 1'b0;
      end
      if (w_sample_data) r_shift[r_bit] <= w_rx_s;
      if (w_sample_par)  r_mismatch     <= w_par_mis;
      if (w_stop_good)   r_data_out     <= r_shift;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm : frame-level scoreboard bench for three receiver configs
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fsm;

  localparam int NB  [3] = '{8, 8, 5};
  localparam int PAR [3] = '{0, 2, 1};
  localparam int CPB = 16;

  typedef struct {
    int         dut;
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
    int         t;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      rx  = 3'b111;
  logic [2:0][7:0] dout;
  logic [2:0]      dv, pe, fe, bz;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  ev_t q[$];
  logic [7:0] last_good [3];
  int dv_cnt [3], fe_cnt [3], last_dv_cyc [3], prev_dv_cyc [3];
  logic [7:0] last_dv_data [3], prev_dv_data [3];
  logic last_pe [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fsm #(.clks_per_bit(CPB), .rx_num_bits(8), .parity(0)) u_dut_none (
    .clk(clk), .RST(rst), .RX(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));
  uart_rx_fsm #(.clks_per_bit(CPB), .rx_num_bits(8), .parity(2)) u_dut_even (
    .clk(clk), .RST(rst), .RX(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));
  uart_rx_fsm #(.clks_per_bit(CPB), .rx_num_bits(5), .parity(1)) u_dut_odd5 (
    .clk(clk), .RST(rst), .RX(rx[2]), .data_out(dout[2]), .data_valid(dv[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: each frame predicts one pulse at a fixed delay after its
  // start edge (2 sync + 1 detect + half bit + remaining bits up to mid-stop + 1).
  task automatic send_frame(input int d, input logic [7:0] data, input bit flip,
                            input bit stop_v, input bit push);
    int nb, hp;
    logic [7:0] dm;
    bit pb, mism;
    nb = NB[d];
    hp = (PAR[d] != 0) ? 1 : 0;
    dm = data & 8'((1 << nb) - 1);
    pb = ((PAR[d] == 1) ? ~(^dm) : (^dm)) ^ flip;
    mism = (PAR[d] == 1) ? ((^dm ^ pb) == 1'b0) : (PAR[d] == 2) ? ((^dm ^ pb) == 1'b1) : 1'b0;
    @(posedge clk); #1;
    if (push) q.push_back('{d, !stop_v, dm, (stop_v ? mism : 1'b0), cyc + 12 + CPB * (nb + hp + 1)});
    rx[d] = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < nb; i++) begin
      #1 rx[d] = dm[i];
      repeat (CPB) @(posedge clk);
    end
    if (hp != 0) begin
      #1 rx[d] = pb;
      repeat (CPB) @(posedge clk);
    end
    #1 rx[d] = stop_v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    int idx;
    ev_t ev;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        chk("reset_outputs", {dout[d], dv[d], pe[d], fe[d], bz[d]}, 0);
        last_good[d] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        idx = -1;
        for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].dut == d) idx = i;
        if (dv[d] || fe[d] || pe[d]) begin
          if (idx < 0) begin
            chk("unexpected_pulse", {dv[d], pe[d], fe[d]}, 0);
          end else begin
            ev = q[idx];
            q.delete(idx);
            n_tests++;
            if (cyc < ev.t - 1 || cyc > ev.t + 1) begin
              n_fail++;
              $display("FAIL pulse_time dut%0d: got cycle %0d expected %0d", d, cyc, ev.t);
            end
            if (ev.is_ferr) begin
              chk("ferr_pulse", {dv[d], pe[d], fe[d]}, 3'b001);
              chk("ferr_data_hold", dout[d], last_good[d]);
              fe_cnt[d]++;
            end else begin
              chk("dv_pulse", {dv[d], pe[d], fe[d]}, {1'b1, ev.perr, 1'b0});
              chk("dv_data", dout[d], ev.data);
              last_good[d]    = ev.data;
              dv_cnt[d]++;
              prev_dv_cyc[d]  = last_dv_cyc[d];
              last_dv_cyc[d]  = cyc;
              prev_dv_data[d] = last_dv_data[d];
              last_dv_data[d] = dout[d];
              last_pe[d]      = pe[d];
            end
          end
        end else begin
          chk("data_hold", dout[d], last_good[d]);
          if (idx >= 0 && cyc > q[idx].t + 1) begin
            chk("missed_pulse", 0, 1);
            q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int c0, f0, t;
    for (int d = 0; d < 3; d++) begin
      last_good[d] = 8'h00; dv_cnt[d] = 0; fe_cnt[d] = 0;
      last_dv_cyc[d] = 0; prev_dv_cyc[d] = 0;
      last_dv_data[d] = 8'h00; prev_dv_data[d] = 8'h00; last_pe[d] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    // Parity none, 0xA5
    c0 = dv_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("a5_count", dv_cnt[0] - c0, 1);
    chk("a5_data", last_dv_data[0], 8'hA5);
    chk("a5_perr", last_pe[0], 0);

    // Back-to-back 0x81, 0x7E
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("b2b_first", prev_dv_data[0], 8'h81);
    chk("b2b_second", last_dv_data[0], 8'h7E);
    chk("b2b_spacing_ok", (last_dv_cyc[0] - prev_dv_cyc[0] >= 158) &&
                          (last_dv_cyc[0] - prev_dv_cyc[0] <= 162), 1);

    // Bad stop, long break, then 0x12
    c0 = dv_cnt[0]; f0 = fe_cnt[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (40 * CPB) @(posedge clk);
    #1 rx[0] = 1'b1;
    repeat (32) @(posedge clk); #1;
    chk("break_ferr_count", fe_cnt[0] - f0, 1);
    chk("break_data_hold", dout[0], 8'h7E);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("break_then_12", dout[0], 8'h12);
    chk("break_dv_count", dv_cnt[0] - c0, 1);

    // Six-cycle glitch on an idle line
    @(posedge clk); #1 rx[0] = 1'b0; t = cyc;
    repeat (4) @(posedge clk); #1;
    chk("glitch_busy_high", bz[0], 1);
    repeat (2) @(posedge clk); #1 rx[0] = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("glitch_busy_low", bz[0], 0);

    // Even parity, 0x3C with parity bit 1
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("even_3c_data", last_dv_data[1], 8'h3C);
    chk("even_3c_perr", last_pe[1], 1);

    // Reset during data bit 4, then 0xC3
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (CPB * 5 + 8) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (20) @(posedge clk); #1;
    chk("post_reset_idle", bz[0], 0);
    chk("post_reset_data", dout[0], 8'h00);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    chk("post_reset_c3", dout[0], 8'hC3);

    // Randomized frames on every configuration
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 12; n++) begin
        bit flip, stop_v;
        flip   = (PAR[d] != 0) && ($urandom_range(0, 3) == 0);
        stop_v = ($urandom_range(0, 5) != 0);
        send_frame(d, 8'($urandom), flip, stop_v, 1'b1);
        if (!stop_v) begin
          repeat (CPB * $urandom_range(0, 3)) @(posedge clk);
          #1 rx[d] = 1'b1;
          repeat (2 + $urandom_range(0, 10)) @(posedge clk);
        end else if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 20)) @(posedge clk);
        end
      end
      repeat (30) @(posedge clk);
    end

    repeat (200) @(posedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
